// File: rtl/plic_gateway_if.sv
// Claim/completion sideband between the PLIC and the interrupt gateway.
// Both valids are single-cycle pulses with no back-pressure (no ready); an id
// is meaningful only in the cycle its valid is high, and every pulse is consumed.
interface plic_gateway_if;
    logic       claim_valid_i;
    logic [4:0] claim_id_i;
    logic       complete_valid_i;
    logic [4:0] complete_id_i;

    modport master (output claim_valid_i, claim_id_i, complete_valid_i, complete_id_i);
    modport slave  (input  claim_valid_i, claim_id_i, complete_valid_i, complete_id_i);
endinterface

// File: rtl/plic_gateway.sv
// PLIC interrupt gateway: synchronises raw lines, turns edge/level sources into
// one-at-a-time requests. Optional sticky edge-overflow flags: GATEWAY_OVERFLOW_STATUS_EN.
module plic_gateway #(
    parameter int          NSRC        = 31,
    parameter int          SYNC_STAGES = 2,
    parameter logic [30:0] EDGE_MASK   = 31'h0,
    parameter int          MAX_PENDING = 3
) (
    input  logic              gateway_clock_i,
    input  logic              gateway_reset_i,
    input  logic [NSRC-1:0]   irq_i,
    plic_gateway_if.slave     plic,
    output logic [NSRC-1:0]   int_o,
    output logic [2*NSRC-1:0] dbg_state_o
`ifdef GATEWAY_OVERFLOW_STATUS_EN
    ,
    output logic [NSRC-1:0]   overflow_o,
    input  logic [NSRC-1:0]   overflow_clr_i
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ASSERTED   = 2'd1,
        ST_IN_SERVICE = 2'd2
    } state_e;

    localparam logic [3:0] CNT_MAX = 4'(MAX_PENDING);

    logic [SYNC_STAGES-1:0][NSRC-1:0] r_sync;
    logic [NSRC-1:0]                  r_s_prev;
    logic                             w_same_id;

    always_ff @(posedge gateway_clock_i or posedge gateway_reset_i) begin
        if (gateway_reset_i) begin
            r_sync   <= '0;
            r_s_prev <= '0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], irq_i};
            r_s_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // A claim and completion naming the same ID in one cycle cancel each other.
    assign w_same_id = plic.claim_valid_i && plic.complete_valid_i &&
                       (plic.claim_id_i == plic.complete_id_i);

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        localparam logic [4:0] SRC_ID  = 5'(gi + 1);
        localparam bit         IS_EDGE = EDGE_MASK[gi];

        state_e     r_state, w_state_nxt;
        logic [3:0] r_cnt, w_cnt_nxt;
        logic       r_int;
        logic       w_s, w_rise, w_claim, w_complete, w_pending;

        assign w_s        = r_sync[SYNC_STAGES-1][gi];
        assign w_rise     = w_s & ~r_s_prev[gi];
        assign w_claim    = plic.claim_valid_i && (plic.claim_id_i == SRC_ID) &&
                            !w_same_id && (r_state == ST_ASSERTED);
        assign w_complete = plic.complete_valid_i && (plic.complete_id_i == SRC_ID) &&
                            !w_same_id && (r_state == ST_IN_SERVICE);
        assign w_pending  = IS_EDGE ? (r_cnt != 4'd0) : w_s;

        always_comb begin
            w_state_nxt = r_state;
            unique case (r_state)
                ST_IDLE:       if (w_pending) w_state_nxt = ST_ASSERTED;
                ST_ASSERTED: begin
                    // A claim beats a level line falling in the same cycle.
                    if (w_claim)                w_state_nxt = ST_IN_SERVICE;
                    else if (!IS_EDGE && !w_s)  w_state_nxt = ST_IDLE;
                end
                ST_IN_SERVICE: if (w_complete) w_state_nxt = ST_IDLE;
                default:       w_state_nxt = ST_IDLE;
            endcase
        end

        always_comb begin
            w_cnt_nxt = r_cnt;
            if (IS_EDGE) begin
                if (w_rise && !w_claim) begin
                    if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 4'd1;
                end else if (!w_rise && w_claim) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
        end

        always_ff @(posedge gateway_clock_i or posedge gateway_reset_i) begin
            if (gateway_reset_i) begin
                r_state <= ST_IDLE;
                r_cnt   <= 4'd0;
                r_int   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_int   <= (w_state_nxt == ST_ASSERTED);
            end
        end

        assign int_o[gi]             = r_int;
        assign dbg_state_o[2*gi +: 2] = r_state;

`ifdef GATEWAY_OVERFLOW_STATUS_EN
        logic r_ovf, w_drop;
        assign w_drop = IS_EDGE && w_rise && !w_claim && (r_cnt == CNT_MAX);

        always_ff @(posedge gateway_clock_i or posedge gateway_reset_i) begin
            if (gateway_reset_i)         r_ovf <= 1'b0;
            else if (w_drop)             r_ovf <= 1'b1;
            else if (overflow_clr_i[gi]) r_ovf <= 1'b0;
        end

        assign overflow_o[gi] = r_ovf;
`endif
    end

endmodule
